muldiv_sequencer: RTL and testbench

- Iterative RV32M multiply/divide unit beside the execute-stage ALU, for MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
- Operands are accepted on a valid/ready handshake, and one add-or-subtract/shift step runs per clock.
- The result is held on a valid/ready output until consumed.
- Pipeline control may squash an in-flight operation with flush.

---
 rtl/muldiv_sequencer.sv | 173 +++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative RV32M multiply/divide unit with valid/ready handshakes
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_FIXUP = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [2:0]         funct3_q;
    logic               sign_a_q, sign_b_q;
    logic [WIDTH-1:0]   a_mag_q, b_mag_q;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH:0]     rem_q, rem_d;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   out_q;

    logic               accept;
    logic               a_signed, b_signed;
    logic               sign_a, sign_b;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               div_zero, div_ovf, special;
    logic [WIDTH-1:0]   special_res;
    logic [WIDTH:0]     div_shift, div_trial;
    logic               div_fits;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quot_s, rem_s, fix_res;

    assign accept = in_valid && in_ready && !flush;

    // Operand decode at the accept edge
    always_comb begin
        a_signed    = (funct3 == 3'b001) || (funct3 == 3'b010) ||
                      (funct3 == 3'b100) || (funct3 == 3'b110);
        b_signed    = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
        sign_a      = a_signed && in_a[WIDTH-1];
        sign_b      = b_signed && in_b[WIDTH-1];
        a_mag       = sign_a ? -in_a : in_a;
        b_mag       = sign_b ? -in_b : in_b;
        div_zero    = funct3[2] && (in_b == '0);
        div_ovf     = funct3[2] && !funct3[0] &&
                      (in_a == {1'b1, {(WIDTH-1){1'b0}}}) && (in_b == '1);
        special     = div_zero || div_ovf;
        special_res = '0;
        if (div_zero) begin
            special_res = funct3[1] ? in_a : '1;
        end else if (div_ovf) begin
            special_res = funct3[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
        end
    end

    // Shift-add multiply: the multiplier sits in the low half and drains out as the sum shifts in
    always_comb begin
        mul_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, a_mag_q} : '0);
        prod_d  = {mul_sum, prod_q[WIDTH-1:1]};
    end

    // Restoring divide: the dividend shifts out of prod_q's low half while quotient bits shift in
    always_comb begin
        div_shift = {rem_q[WIDTH-1:0], prod_q[WIDTH-1]};
        div_trial = div_shift - {1'b0, b_mag_q};
        div_fits  = rem_q[WIDTH] || !div_trial[WIDTH];
        rem_d     = div_fits ? div_trial : div_shift;
    end

    always_comb begin
        prod_s  = (sign_a_q ^ sign_b_q) ? -prod_q : prod_q;
        quot_s  = (sign_a_q ^ sign_b_q) ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
        rem_s   = sign_a_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
        fix_res = '0;
        case (funct3_q)
            3'b000:                 fix_res = prod_s[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod_s[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         fix_res = quot_s;
            default:                fix_res = rem_s;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = special ? S_DONE : S_CALC;
            S_CALC:  if (cnt_q == CNT_LAST) state_d = S_FIXUP;
            S_FIXUP: state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d = S_IDLE;
        end
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
    end

    // A flushed operation must not disturb the held result, so datapath updates stall on flush
    always_ff @(posedge clock) begin
        if (!reset) begin
            funct3_q <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            a_mag_q  <= '0;
            b_mag_q  <= '0;
            prod_q   <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            out_q    <= '0;
        end else if (!flush) begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        funct3_q <= funct3;
                        sign_a_q <= sign_a;
                        sign_b_q <= sign_b;
                        a_mag_q  <= a_mag;
                        b_mag_q  <= b_mag;
                        prod_q   <= {{WIDTH{1'b0}}, (funct3[2] ? a_mag : b_mag)};
                        rem_q    <= '0;
                        cnt_q    <= '0;
                        if (special) begin
                            out_q <= special_res;
                        end
                    end
                end
                S_CALC: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (funct3_q[2]) begin
                        rem_q  <= rem_d;
                        prod_q <= {{WIDTH{1'b0}}, prod_q[WIDTH-2:0], div_fits};
                    end else begin
                        prod_q <= prod_d;
                    end
                end
                S_FIXUP: out_q <= fix_res;
                default: ;
            endcase
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - directed-vector bench for muldiv_sequencer
module tb_muldiv_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  funct3;
    logic [31:0] in_a, in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;

    int errors = 0;
    int checks = 0;

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .funct3    (funct3),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge in IDLE; lat counts cycles from the accept cycle to the first out_valid cycle
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                          input int hold);
        int          lat;
        logic        stable;
        logic [31:0] held;
        chk({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
        funct3   = f;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        in_a     = ~a;
        in_b     = ~b;
        funct3   = ~f;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(negedge clock);
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_out"}, {32'd0, out}, {32'd0, exp});
        if (hold > 0) begin
            stable = 1'b1;
            held   = out;
            for (int i = 0; i < hold; i++) begin
                @(negedge clock);
                if (!out_valid || out !== held || in_ready) stable = 1'b0;
            end
            chk({tag, "_hold_stable"}, {63'd0, stable}, 64'd1);
        end
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        chk({tag, "_consumed_valid"}, {63'd0, out_valid}, 64'd0);
        chk({tag, "_consumed_ready"}, {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        logic seen;
        reset     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b1;
        funct3    = 3'b000;
        in_a      = 32'd3;
        in_b      = 32'd4;
        out_ready = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_hold_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_hold_out", {32'd0, out}, 64'd0);
        reset    = 1'b1;
        in_valid = 1'b0;
        chk("rst_rel_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clock);
        chk("rst_idle_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_idle_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_idle_out", {32'd0, out}, 64'd0);

        run_op("mul_neg",   3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34, 0);
        run_op("mul_zero",  3'b000, 32'd0,        32'd5,        32'd0,        34, 0);
        run_op("mulh",      3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34, 0);
        run_op("mulhu",     3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, 0);
        run_op("mulhsu",    3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, 0);
        run_op("div_neg",   3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34, 0);
        run_op("rem_neg",   3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34, 0);
        run_op("div_min",   3'b100, 32'h80000000, 32'd2,        32'hC0000000, 34, 0);
        run_op("divu",      3'b101, 32'd100,      32'd7,        32'd14,       34, 0);
        run_op("remu_hold", 3'b111, 32'd100,      32'd7,        32'd2,        34, 10);
        run_op("divu_z",    3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1,  0);
        run_op("rem_z",     3'b110, 32'd5,        32'd0,        32'd5,        1,  0);
        run_op("div_ovf",   3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  0);
        run_op("rem_ovf",   3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1,  0);

        funct3   = 3'b000;
        in_a     = 32'd5;
        in_b     = 32'd6;
        in_valid = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        repeat (10) @(negedge clock);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        chk("flush_ready", {63'd0, in_ready}, 64'd1);
        seen = 1'b0;
        repeat (50) begin
            @(negedge clock);
            if (out_valid) seen = 1'b1;
        end
        chk("flush_no_valid", {63'd0, seen}, 64'd0);

        flush    = 1'b1;
        in_valid = 1'b1;
        @(negedge clock);
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_idle_no_accept", {63'd0, in_ready}, 64'd1);
        run_op("mul_after_flush", 3'b000, 32'd3, 32'd4, 32'd12, 34, 0);

        funct3   = 3'b011;
        in_a     = 32'hFFFFFFFF;
        in_b     = 32'hFFFFFFFF;
        in_valid = 1'b1;
        @(negedge clock);
        in_valid = 1'b0;
        repeat (10) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        chk("midrst_out", {32'd0, out}, 64'd0);
        chk("midrst_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_ready", {63'd0, in_ready}, 64'd1);
        seen = 1'b0;
        repeat (50) begin
            @(negedge clock);
            if (out_valid) seen = 1'b1;
        end
        chk("midrst_no_valid", {63'd0, seen}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
